line_mem_responder: RTL

- Line-granular backing memory that acts as the responder on the L3-to-ram link; it is the far end of the `re`/`we` plus `read_hit`/`write_hit` handshake driven by L3.
- It services one read or one write line at a time, with programmable access latency, so that cache miss and writeback timing is realistic in simulation.
- It replaces the zero-latency ram stub at the bottom of the hierarchy and runs on the L3 clock.

---
 rtl/line_mem_responder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/line_mem_responder.sv
// Line-granular backing memory answering the L3 re/we handshake with
// programmable read and write latency; services one line request at a time.
module line_mem_responder #(
    parameter int ADDR_LENTH = 32,
    parameter int LINE_SIZE  = 256,
    parameter int DEPTH      = 1024,
    parameter int READ_LAT   = 4,
    parameter int WRITE_LAT  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  re_L3_ram,
    input  logic [ADDR_LENTH-1:0] raddr_L3_ram,
    output logic [LINE_SIZE-1:0]  rdata_L3_ram,
    output logic                  read_hit_L3_ram,
    input  logic                  we_L3_ram,
    input  logic [ADDR_LENTH-1:0] waddr_L3_ram,
    input  logic [LINE_SIZE-1:0]  wdata_L3_ram,
    output logic                  write_hit_L3_ram
);

    localparam int OFF     = $clog2(LINE_SIZE / 8);
    localparam int IW      = $clog2(DEPTH);
    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [CW-1:0] RLOAD = CW'(READ_LAT - 1);
    localparam logic [CW-1:0] WLOAD = CW'(WRITE_LAT - 1);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        RBUSY,
        WBUSY,
        RDONE,
        WDONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_next;
    logic [IW-1:0]        idx_q;
    logic [LINE_SIZE-1:0] wline_q;

    logic [LINE_SIZE-1:0] mem [DEPTH];

    logic [IW-1:0]        raddr_idx;
    logic [IW-1:0]        waddr_idx;
    logic                 capture_w;
    logic                 capture_r;
    logic                 do_read;
    logic                 do_write;
    logic [IW-1:0]        read_idx;
    logic [IW-1:0]        write_idx;
    logic [LINE_SIZE-1:0] write_line;

    // Offset bits and bits above the index are dropped, so addresses alias modulo DEPTH.
    assign raddr_idx = raddr_L3_ram[OFF +: IW];
    assign waddr_idx = waddr_L3_ram[OFF +: IW];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{raddr_L3_ram, waddr_L3_ram};

    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        capture_w        = 1'b0;
        capture_r        = 1'b0;
        do_read          = 1'b0;
        do_write         = 1'b0;
        read_idx         = idx_q;
        write_idx        = idx_q;
        write_line       = wline_q;
        read_hit_L3_ram  = 1'b0;
        write_hit_L3_ram = 1'b0;

        case (state)
            IDLE: begin
                // A simultaneous read stays pending and is taken after the write completes.
                if (we_L3_ram) begin
                    capture_w = 1'b1;
                    if (WRITE_LAT == 1) begin
                        do_write   = 1'b1;
                        write_idx  = waddr_idx;
                        write_line = wdata_L3_ram;
                        state_next = WDONE;
                    end else begin
                        cnt_next   = WLOAD;
                        state_next = WBUSY;
                    end
                end else if (re_L3_ram) begin
                    capture_r = 1'b1;
                    if (READ_LAT == 1) begin
                        do_read    = 1'b1;
                        read_idx   = raddr_idx;
                        state_next = RDONE;
                    end else begin
                        cnt_next   = RLOAD;
                        state_next = RBUSY;
                    end
                end
            end

            RBUSY: begin
                if (!re_L3_ram) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (cnt == ONE) begin
                    cnt_next   = '0;
                    do_read    = 1'b1;
                    state_next = RDONE;
                end else begin
                    cnt_next = cnt - ONE;
                end
            end

            WBUSY: begin
                if (!we_L3_ram) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (cnt == ONE) begin
                    cnt_next   = '0;
                    do_write   = 1'b1;
                    state_next = WDONE;
                end else begin
                    cnt_next = cnt - ONE;
                end
            end

            RDONE: begin
                read_hit_L3_ram = 1'b1;
                state_next      = IDLE;
            end

            WDONE: begin
                write_hit_L3_ram = 1'b1;
                state_next       = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            idx_q        <= '0;
            wline_q      <= '0;
            rdata_L3_ram <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (capture_w) begin
                idx_q   <= waddr_idx;
                wline_q <= wdata_L3_ram;
            end else if (capture_r) begin
                idx_q <= raddr_idx;
            end
            if (do_read) begin
                rdata_L3_ram <= mem[read_idx];
            end
        end
    end

    // Storage is deliberately outside the reset domain; reset only blocks a pending write.
    always_ff @(posedge clk) begin
        if (do_write && !rst) begin
            mem[write_idx] <= write_line;
        end
    end

    hits_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(read_hit_L3_ram && write_hit_L3_ram));

endmodule
